// File: rtl/cmd_frame_if.sv
// Host byte stream in, magic/command handshake out, plus frame statistics.
// The slave modport is the assembler's view; the master modport is the host/bank side.
interface cmd_frame_if;
  logic [7:0]  i_byte;
  logic        i_byte_vld;
  logic        o_byte_rdy;
  logic [31:0] o_cmd_magic;
  logic [31:0] o_cmd_command;
  logic        o_cmd_vld;
  logic        i_cmd_rdy;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  modport slave (
    input  i_byte, i_byte_vld, i_cmd_rdy,
    output o_byte_rdy, o_cmd_magic, o_cmd_command, o_cmd_vld,
           o_frame_cnt, o_err_cnt, o_busy
  );

  modport master (
    output i_byte, i_byte_vld, i_cmd_rdy,
    input  o_byte_rdy, o_cmd_magic, o_cmd_command, o_cmd_vld,
           o_frame_cnt, o_err_cnt, o_busy
  );
endinterface

// File: rtl/cmd_frame_assembler.sv
// Hunts a byte stream for MAGIC, collects the following 32-bit command and
// hands magic+command to the parameter bank; aborts stalled frames on timeout.
module cmd_frame_assembler #(
  parameter logic [31:0] MAGIC       = 32'hF0AA550F,
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  cmd_frame_if.slave  bus
);

  typedef enum logic [1:0] {HUNT, CMD, OUT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state, state_n;
  logic [23:0]     sr, sr_n;
  logic [1:0]      idx, idx_n;
  logic [31:0]     cmd, cmd_n;
  logic [TO_W-1:0] to_cnt, to_n;

  logic        cmd_vld;
  logic [31:0] cmd_magic;
  logic [31:0] cmd_command;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  logic byte_rdy;
  logic byte_acc;
  logic load_out;
  logic xfer;
  logic abort_err;

  // Ready depends on the state register only, so i_cmd_rdy never reaches it
  assign byte_rdy = (state != OUT);
  assign byte_acc = bus.i_byte_vld & byte_rdy;

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    idx_n     = idx;
    cmd_n     = cmd;
    to_n      = to_cnt;
    load_out  = 1'b0;
    xfer      = 1'b0;
    abort_err = 1'b0;

    unique case (state)
      HUNT: begin
        if (byte_acc) begin
          to_n = '0;
          if ({sr, bus.i_byte} == MAGIC) begin
            state_n = CMD;
            sr_n    = '0;
            idx_n   = '0;
            cmd_n   = '0;
          end else begin
            sr_n = {sr[15:0], bus.i_byte};
          end
        end else if (sr != '0) begin
          // A stale partial sync is dropped silently, without an error
          if (to_cnt == TO_LAST) begin
            sr_n  = '0;
            cmd_n = '0;
            to_n  = '0;
          end else begin
            to_n = to_cnt + TO_W'(1);
          end
        end else begin
          to_n = '0;
        end
      end

      CMD: begin
        if (byte_acc) begin
          cmd_n = {cmd[23:0], bus.i_byte};
          idx_n = idx + 2'd1;
          to_n  = '0;
          if (idx == 2'd3) begin
            state_n  = OUT;
            load_out = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          state_n   = HUNT;
          abort_err = 1'b1;
          sr_n      = '0;
          cmd_n     = '0;
          idx_n     = '0;
          to_n      = '0;
        end else begin
          to_n = to_cnt + TO_W'(1);
        end
      end

      OUT: begin
        to_n = '0;
        if (bus.i_cmd_rdy) begin
          xfer    = 1'b1;
          state_n = HUNT;
          idx_n   = '0;
        end
      end

      default: begin
        state_n = HUNT;
        sr_n    = '0;
        idx_n   = '0;
        cmd_n   = '0;
        to_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sr          <= '0;
      idx         <= '0;
      cmd         <= '0;
      to_cnt      <= '0;
      cmd_vld     <= 1'b0;
      cmd_magic   <= '0;
      cmd_command <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      idx    <= idx_n;
      cmd    <= cmd_n;
      to_cnt <= to_n;

      // Output words are captured on the last byte and held until overwritten
      if (load_out) begin
        cmd_vld     <= 1'b1;
        cmd_magic   <= MAGIC;
        cmd_command <= cmd_n;
      end else if (xfer) begin
        cmd_vld <= 1'b0;
      end

      if (xfer) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (abort_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign bus.o_byte_rdy    = byte_rdy;
  assign bus.o_busy        = (state != HUNT) || (sr != '0);
  assign bus.o_cmd_vld     = cmd_vld;
  assign bus.o_cmd_magic   = cmd_magic;
  assign bus.o_cmd_command = cmd_command;
  assign bus.o_frame_cnt   = frame_cnt;
  assign bus.o_err_cnt     = err_cnt;

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Directed and randomized stimulus for cmd_frame_assembler, checked against a
// byte-level frame model (sliding sync window, 4-byte command collection).
module tb_cmd_frame_assembler;

  localparam logic [31:0] MAGIC = 32'hF0AA550F;
  localparam int unsigned T     = 16;

  logic clk;
  logic rst_n;
  logic rdy_mode;
  logic rdy_val;
  logic rdy_rand;

  cmd_frame_if bus ();

  assign bus.i_cmd_rdy = rdy_mode ? rdy_rand : rdy_val;

  cmd_frame_assembler #(
    .MAGIC       (MAGIC),
    .TIMEOUT_CYC (T),
    .TO_W        (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] got_magic_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  win[$];
  logic [7:0]  cmdb[$];
  bit          collecting;
  int unsigned exp_err;
  int unsigned exp_frames;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rdy_rand = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  // Handshake inputs change only just after posedge, so negedge sees the transfer
  always @(negedge clk) begin
    if (rst_n && bus.o_cmd_vld && bus.i_cmd_rdy) begin
      got_q.push_back(bus.o_cmd_command);
      got_magic_q.push_back(bus.o_cmd_magic);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    cmdb.delete();
    collecting = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_magic_q.delete();
    exp_err    = 0;
    exp_frames = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (collecting) begin
      cmdb.push_back(b);
      if (cmdb.size() == 4) begin
        exp_q.push_back({cmdb[0], cmdb[1], cmdb[2], cmdb[3]});
        exp_frames++;
        collecting = 1'b0;
        cmdb.delete();
      end
    end else begin
      win.push_back(b);
      if (win.size() > 4) void'(win.pop_front());
      if (win.size() == 4 && {win[0], win[1], win[2], win[3]} == MAGIC) begin
        collecting = 1'b1;
        win.delete();
      end
    end
  endtask

  // Called after the line has been idle for at least T cycles
  task automatic model_idle_timeout();
    if (collecting && exp_err < 255) exp_err++;
    collecting = 1'b0;
    cmdb.delete();
    win.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    bus.i_byte     = b;
    bus.i_byte_vld = 1'b1;
    n = 0;
    while (!bus.o_byte_rdy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      check("byte_accept_timeout", 32'(bus.o_byte_rdy), 32'd1);
      bus.i_byte_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.i_byte_vld = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] c);
    send_word(MAGIC);
    send_word(c);
  endtask

  task automatic compare_frames(input string tag);
    int unsigned n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_cmd"}, got_q[i], exp_q[i]);
      check({tag, "_magic"}, got_magic_q[i], MAGIC);
    end
    got_q.delete();
    got_magic_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus.i_byte_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    rdy_mode       = 1'b0;
    rdy_val        = 1'b1;
    bus.i_byte     = '0;
    bus.i_byte_vld = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    idle(3);
    rst_n = 1'b1;

    // Reset state
    check("rst_byte_rdy", 32'(bus.o_byte_rdy), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_vld", 32'(bus.o_cmd_vld), 32'd0);
    check("rst_magic", bus.o_cmd_magic, 32'd0);
    check("rst_command", bus.o_cmd_command, 32'd0);
    check("rst_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(bus.o_err_cnt), 32'd0);

    // Basic frame and one-cycle latency
    send_frame(32'h04800078);
    check("t1_vld", 32'(bus.o_cmd_vld), 32'd1);
    check("t1_magic", bus.o_cmd_magic, MAGIC);
    check("t1_command", bus.o_cmd_command, 32'h04800078);
    check("t1_byte_rdy_out", 32'(bus.o_byte_rdy), 32'd0);
    idle(1);
    check("t1_vld_drop", 32'(bus.o_cmd_vld), 32'd0);
    check("t1_frame_cnt", 32'(bus.o_frame_cnt), 32'(exp_frames));
    check("t1_byte_rdy", 32'(bus.o_byte_rdy), 32'd1);
    check("t1_cmd_hold", bus.o_cmd_command, 32'h04800078);
    compare_frames("t1");

    // Garbage with overlapping sync
    send_byte(8'h12);
    send_byte(8'hF0);
    send_word(MAGIC);
    send_word(32'hDEADBEEF);
    idle(2);
    compare_frames("t2");
    check("t2_err_cnt", 32'(bus.o_err_cnt), 32'd0);
    check("t2_frame_cnt", 32'(bus.o_frame_cnt), 32'(exp_frames));

    // Command-phase timeout, then a good frame
    send_word(MAGIC);
    send_byte(8'h11);
    send_byte(8'h22);
    check("t3_busy_cmd", 32'(bus.o_busy), 32'd1);
    idle(T + 2);
    model_idle_timeout();
    check("t3_err_cnt", 32'(bus.o_err_cnt), 32'(exp_err));
    check("t3_busy_idle", 32'(bus.o_busy), 32'd0);
    send_frame(32'hCAFE0001);
    idle(2);
    compare_frames("t3");

    // Byte arriving on the last allowed cycle beats the timeout
    send_word(MAGIC);
    send_byte(8'hA1);
    idle(T - 1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    idle(2);
    compare_frames("t3b");
    check("t3b_err_cnt", 32'(bus.o_err_cnt), 32'(exp_err));

    // Partial sync in HUNT times out silently
    send_byte(8'hF0);
    send_byte(8'hAA);
    send_byte(8'h55);
    check("t3c_busy_partial", 32'(bus.o_busy), 32'd1);
    idle(T + 2);
    model_idle_timeout();
    check("t3c_busy_cleared", 32'(bus.o_busy), 32'd0);
    send_byte(8'h0F);
    send_frame(32'h00C0FFEE);
    idle(2);
    compare_frames("t3c");
    check("t3c_err_cnt", 32'(bus.o_err_cnt), 32'(exp_err));

    // Downstream stall with next frame pending
    rdy_val = 1'b0;
    send_frame(32'h13572468);
    bus.i_byte     = 8'hF0;
    bus.i_byte_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_byte_rdy", 32'(bus.o_byte_rdy), 32'd0);
      check("t4_stall_vld", 32'(bus.o_cmd_vld), 32'd1);
      check("t4_stall_cmd", bus.o_cmd_command, 32'h13572468);
      idle(1);
    end
    rdy_val = 1'b1;
    idle(1);
    check("t4_xfer_vld", 32'(bus.o_cmd_vld), 32'd0);
    check("t4_xfer_byte_rdy", 32'(bus.o_byte_rdy), 32'd1);
    send_frame(32'h9ABCDEF0);
    idle(2);
    compare_frames("t4");
    check("t4_frame_cnt", 32'(bus.o_frame_cnt), 32'(exp_frames));

    // Reset mid-frame discards the partial command
    send_word(MAGIC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    do_reset();
    check("t5_rst_vld", 32'(bus.o_cmd_vld), 32'd0);
    check("t5_rst_command", bus.o_cmd_command, 32'd0);
    check("t5_rst_busy", 32'(bus.o_busy), 32'd0);
    send_frame(32'h55AA0F0F);
    idle(2);
    compare_frames("t5");
    check("t5_frame_cnt", 32'(bus.o_frame_cnt), 32'd1);
    check("t5_err_cnt", 32'(bus.o_err_cnt), 32'd0);

    // Randomized stream against the model, random downstream ready
    rdy_mode = 1'b1;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_frame($urandom);
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          case ($urandom_range(0, 4))
            0: w = 32'hF0;
            1: w = 32'hAA;
            2: w = 32'h55;
            3: w = 32'h0F;
            default: w = $urandom;
          endcase
          send_byte(w[7:0]);
          idle($urandom_range(0, 3));
        end
      end
      idle($urandom_range(0, 3));
    end
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    idle(T + 4);
    model_idle_timeout();
    compare_frames("rnd");
    check("rnd_frame_cnt", 32'(bus.o_frame_cnt), 32'(exp_frames));
    check("rnd_err_cnt", 32'(bus.o_err_cnt), 32'(exp_err));

    // Error counter saturation
    do_reset();
    for (int r = 0; r < 300; r++) begin
      send_word(MAGIC);
      send_byte(8'(r));
      idle(T + 2);
      model_idle_timeout();
      if (r == 100) check("t6_err_mid", 32'(bus.o_err_cnt), 32'(exp_err));
    end
    check("t6_err_model", 32'(bus.o_err_cnt), 32'(exp_err));
    check("t6_err_sat", 32'(bus.o_err_cnt), 32'hFF);
    check("t6_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    check("t6_vld", 32'(bus.o_cmd_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
